// File: rtl/axi_pkg.sv
// Shared AXI encodings and the burst-master state type.
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_WRESP = 3'd2,
      ST_RADDR = 3'd3,
      ST_RDATA = 3'd4
   } state_e;

   function automatic int cnt_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/axi_m_burst_if.sv
// AXI4 five-channel bundle seen from a burst master.
interface axi_m_burst_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 1
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/axi_m_beat_cnt.sv
// Beat counter shared by the W and R data phases; saturates on the last beat.
module axi_m_beat_cnt
   import axi_pkg::*;
#(
   parameter int BEATS = 4,
   parameter int CNT_W = cnt_w(BEATS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign last = (cnt_q == CNT_W'(BEATS - 1));
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && !last)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/axi_m_burst.sv
// Cache-line AXI4 burst master: one line read or write in flight at a time.
module axi_m_burst
   import axi_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINE_W = 128,
   parameter int ID_W   = 1,
   parameter int AXI_ID = 0
) (
   input  logic              M_AXI_ACLK,
   input  logic              M_AXI_ARESETN,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic              rsp_err,
   output logic [LINE_W-1:0] rsp_rdata,
   axi_m_burst_if.master     m_axi
);
   localparam int BEATS    = LINE_W / DATA_W;
   localparam int CNT_W    = cnt_w(BEATS);
   localparam int LINE_OFF = $clog2(LINE_W / 8);
   localparam int AXSIZE   = $clog2(DATA_W / 8);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic              rovr_q, rovr_d, err_q, err_d;
   logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
   logic [LINE_W-1:0] rsp_rdata_q, rsp_rdata_d, wline_q, wline_d, rline_q, rline_d;
   logic              aw_hs, w_hs, r_hs, w_last_hs, beat_err, cnt_clr;
   logic [CNT_W-1:0]  beat_cnt;
   logic              beat_last;

   wire unused_ok = &{1'b0, m_axi.bid, m_axi.rid, req_addr[LINE_OFF-1:0]};

   assign aw_hs     = awvalid_q && m_axi.awready;
   assign w_hs      = wvalid_q && m_axi.wready;
   assign r_hs      = (state_q == ST_RDATA) && m_axi.rvalid;
   assign w_last_hs = w_hs && beat_last;

   axi_m_beat_cnt #(.BEATS(BEATS), .CNT_W(CNT_W)) u_beat_cnt (
      .clk   (M_AXI_ACLK),
      .rst_n (M_AXI_ARESETN),
      .clr   (cnt_clr),
      .inc   (w_hs || r_hs),
      .cnt   (beat_cnt),
      .last  (beat_last)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rovr_d      = rovr_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      wline_d     = wline_q;
      rline_d     = rline_q;
      beat_err    = 1'b0;
      cnt_clr     = 1'b0;
      unique case (state_q)
         ST_IDLE: if (req_valid) begin
            cnt_clr   = 1'b1;
            addr_d    = {req_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            rovr_d    = 1'b0;
            err_d     = 1'b0;
            if (req_write) begin
               wline_d   = req_wdata;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = ST_WR;
            end else begin
               arvalid_d = 1'b1;
               state_d   = ST_RADDR;
            end
         end
         ST_WR: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_last_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs))
               state_d = ST_WRESP;
         end
         ST_WRESP: if (m_axi.bvalid) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_err_d   = (m_axi.bresp != RESP_OKAY);
            state_d     = ST_IDLE;
         end
         ST_RADDR: if (m_axi.arready) begin
            arvalid_d = 1'b0;
            state_d   = ST_RDATA;
         end
         ST_RDATA: if (m_axi.rvalid) begin
            // Once the burst has overrun the line, beats are only drained until RLAST.
            if (!rovr_q)
               rline_d[int'(beat_cnt) * DATA_W +: DATA_W] = m_axi.rdata;
            beat_err = (m_axi.rresp != RESP_OKAY) ||
                       (!rovr_q && (m_axi.rlast != beat_last));
            if (beat_last && !m_axi.rlast)
               rovr_d = 1'b1;
            if (m_axi.rlast) begin
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_err_d   = err_q || beat_err;
               rsp_rdata_d = rline_d;
               state_d     = ST_IDLE;
            end else begin
               err_d = err_q || beat_err;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rovr_q      <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rovr_q      <= rovr_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Line staging buffers carry no control meaning and need no reset.
   always_ff @(posedge M_AXI_ACLK) begin
      wline_q <= wline_d;
      rline_q <= rline_d;
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_err       = rsp_err_q;
   assign rsp_rdata     = rsp_rdata_q;

   assign m_axi.awid    = ID_W'(AXI_ID);
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awlen   = 8'(BEATS - 1);
   assign m_axi.awsize  = 3'(AXSIZE);
   assign m_axi.awburst = BURST_INCR;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wline_q[int'(beat_cnt) * DATA_W +: DATA_W];
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = wvalid_q && beat_last;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = (state_q == ST_WRESP);
   assign m_axi.arid    = ID_W'(AXI_ID);
   assign m_axi.araddr  = addr_q;
   assign m_axi.arlen   = 8'(BEATS - 1);
   assign m_axi.arsize  = 3'(AXSIZE);
   assign m_axi.arburst = BURST_INCR;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = (state_q == ST_RDATA);
endmodule

// File: tb/tb_axi_m_burst.sv
// Directed bench for axi_m_burst: 32/128 instance plus a 64/256 instance under backpressure.
module tb_axi_m_burst;
   import axi_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   logic         req_valid_a = 1'b0, req_write_a = 1'b0;
   logic         req_ready_a, rsp_valid_a, rsp_write_a, rsp_err_a;
   logic [31:0]  req_addr_a = '0;
   logic [127:0] req_wdata_a = '0, rsp_rdata_a;

   logic         req_valid_b = 1'b0, req_write_b = 1'b0;
   logic         req_ready_b, rsp_valid_b, rsp_write_b, rsp_err_b;
   logic [31:0]  req_addr_b = '0;
   logic [255:0] req_wdata_b = '0, rsp_rdata_b;

   axi_m_burst_if #(.ADDR_W(32), .DATA_W(32), .ID_W(1)) ifa ();
   axi_m_burst_if #(.ADDR_W(32), .DATA_W(64), .ID_W(1)) ifb ();

   axi_m_burst #(.ADDR_W(32), .DATA_W(32), .LINE_W(128), .ID_W(1), .AXI_ID(0)) dut_a (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
      .req_addr(req_addr_a), .req_wdata(req_wdata_a),
      .rsp_valid(rsp_valid_a), .rsp_write(rsp_write_a), .rsp_err(rsp_err_a),
      .rsp_rdata(rsp_rdata_a), .m_axi(ifa)
   );

   axi_m_burst #(.ADDR_W(32), .DATA_W(64), .LINE_W(256), .ID_W(1), .AXI_ID(0)) dut_b (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_write(rsp_write_b), .rsp_err(rsp_err_b),
      .rsp_rdata(rsp_rdata_b), .m_axi(ifb)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_slaves();
      ifa.awready = 1'b0; ifa.wready = 1'b0; ifa.bvalid = 1'b0; ifa.bresp = '0; ifa.bid = '0;
      ifa.arready = 1'b0; ifa.rvalid = 1'b0; ifa.rdata = '0; ifa.rresp = '0; ifa.rlast = 1'b0; ifa.rid = '0;
      ifb.awready = 1'b0; ifb.wready = 1'b0; ifb.bvalid = 1'b0; ifb.bresp = '0; ifb.bid = '0;
      ifb.arready = 1'b0; ifb.rvalid = 1'b0; ifb.rdata = '0; ifb.rresp = '0; ifb.rlast = 1'b0; ifb.rid = '0;
   endtask

   task automatic write_a(input logic [31:0] addr, input logic [31:0] exp_awaddr,
                          input logic [127:0] line, input int aw_dly,
                          input logic [1:0] br, input logic exp_err);
      int beat = 0, cyc = 0, since = 0;
      bit aw_seen = 0;
      idle_slaves();
      req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = addr; req_wdata_a = line;
      chk("wr_req_ready", 256'(req_ready_a), 256'(1));
      tick();
      req_valid_a = 1'b0;
      ifa.wready = 1'b1;
      while ((beat < 4 || !aw_seen) && cyc < 60) begin
         ifa.awready = (aw_dly == 0) || (beat == 4 && since >= aw_dly);
         if (ifa.wvalid && ifa.wready) begin
            chk("a_wdata", 256'(ifa.wdata), 256'(line[beat*32 +: 32]));
            chk("a_wlast", 256'(ifa.wlast), 256'(beat == 3));
            beat++;
         end
         if (ifa.awvalid && ifa.awready) begin
            chk("a_awaddr", 256'(ifa.awaddr), 256'(exp_awaddr));
            chk("a_awlen", 256'(ifa.awlen), 256'(3));
            chk("a_awsize", 256'(ifa.awsize), 256'(2));
            chk("a_awburst", 256'(ifa.awburst), 256'(1));
            chk("a_wstrb", 256'(ifa.wstrb), 256'(4'hF));
            aw_seen = 1;
         end
         if (beat == 4) since++;
         tick();
         cyc++;
      end
      chk("a_wr_in_time", 256'(cyc < 60), 256'(1));
      ifa.awready = 1'b0; ifa.wready = 1'b0;
      chk("a_aw_w_dropped", 256'({ifa.awvalid, ifa.wvalid}), 256'(0));
      cyc = 0;
      while (!ifa.bready && cyc < 20) begin tick(); cyc++; end
      chk("a_bready", 256'(ifa.bready), 256'(1));
      chk("a_no_early_rsp", 256'(rsp_valid_a), 256'(0));
      ifa.bvalid = 1'b1; ifa.bresp = br;
      tick();
      ifa.bvalid = 1'b0; ifa.bresp = RESP_OKAY;
      chk("a_wr_rsp_valid", 256'(rsp_valid_a), 256'(1));
      chk("a_wr_rsp_write", 256'(rsp_write_a), 256'(1));
      chk("a_wr_rsp_err", 256'(rsp_err_a), 256'(exp_err));
      chk("a_bready_off", 256'(ifa.bready), 256'(0));
      tick();
      chk("a_wr_rsp_pulse", 256'(rsp_valid_a), 256'(0));
      chk("a_req_ready_back", 256'(req_ready_a), 256'(1));
   endtask

   task automatic read_a(input logic [31:0] addr, input logic [31:0] exp_araddr,
                         input logic [31:0] base, input int nbeats, input int last_at,
                         input int bad_at, input logic exp_err,
                         input logic chk_data, input logic [127:0] exp_line);
      idle_slaves();
      req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = addr;
      tick();
      req_valid_a = 1'b0;
      chk("a_arvalid", 256'(ifa.arvalid), 256'(1));
      chk("a_araddr", 256'(ifa.araddr), 256'(exp_araddr));
      chk("a_arlen", 256'(ifa.arlen), 256'(3));
      chk("a_rready_early", 256'(ifa.rready), 256'(0));
      ifa.arready = 1'b1;
      tick();
      ifa.arready = 1'b0;
      chk("a_arvalid_drop", 256'(ifa.arvalid), 256'(0));
      chk("a_rready", 256'(ifa.rready), 256'(1));
      for (int i = 0; i < nbeats; i++) begin
         ifa.rvalid = 1'b1;
         ifa.rdata  = base + i;
         ifa.rlast  = (i == last_at);
         ifa.rresp  = (i == bad_at) ? RESP_SLVERR : RESP_OKAY;
         tick();
         chk((i == last_at) ? "a_rd_rsp_valid" : "a_rd_no_early_rsp",
             256'(rsp_valid_a), 256'(i == last_at));
      end
      ifa.rvalid = 1'b0; ifa.rlast = 1'b0; ifa.rresp = RESP_OKAY;
      chk("a_rd_rsp_write", 256'(rsp_write_a), 256'(0));
      chk("a_rd_rsp_err", 256'(rsp_err_a), 256'(exp_err));
      if (chk_data) chk("a_rd_rdata", 256'(rsp_rdata_a), 256'(exp_line));
      tick();
      chk("a_rd_rsp_pulse", 256'(rsp_valid_a), 256'(0));
      chk("a_rd_rdata_held", 256'(rsp_rdata_a), chk_data ? 256'(exp_line) : 256'(rsp_rdata_a));
   endtask

   initial begin
      logic [255:0] line_b;
      logic [63:0]  prev;
      bit           have_prev, aw_seen;
      int           beat, cyc;

      idle_slaves();
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_awvalid", 256'(ifa.awvalid), 256'(0));
      chk("rst_wvalid_wlast", 256'({ifa.wvalid, ifa.wlast}), 256'(0));
      chk("rst_arvalid", 256'(ifa.arvalid), 256'(0));
      chk("rst_rsp", 256'({rsp_valid_a, rsp_err_a}), 256'(0));
      chk("rst_rdata", 256'(rsp_rdata_a), 256'(0));
      chk("rst_awaddr", 256'(ifa.awaddr), 256'(0));
      chk("rst_b_rdata", 256'(rsp_rdata_b), 256'(0));
      rst_n = 1'b1;
      chk("req_ready_after_rst", 256'(req_ready_a), 256'(1));

      write_a(32'h0000_1004, 32'h0000_1000,
              128'h44444444_33333333_22222222_11111111, 0, RESP_OKAY, 1'b0);
      read_a(32'h0000_2008, 32'h0000_2000, 32'hA, 4, 3, -1, 1'b0, 1'b1,
             128'h0000000D_0000000C_0000000B_0000000A);
      write_a(32'h0000_5010, 32'h0000_5010,
              128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 5, RESP_SLVERR, 1'b1);
      read_a(32'h0000_2000, 32'h0000_2000, 32'h11, 3, 2, -1, 1'b1, 1'b0, '0);
      read_a(32'h0000_6000, 32'h0000_6000, 32'h21, 6, 5, -1, 1'b1, 1'b1,
             128'h00000024_00000023_00000022_00000021);
      read_a(32'h0000_700C, 32'h0000_7000, 32'h31, 4, 3, 1, 1'b1, 1'b1,
             128'h00000034_00000033_00000032_00000031);

      // Reset while write beat 1 is being presented.
      idle_slaves();
      req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'h0000_3000;
      req_wdata_a = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
      tick();
      req_valid_a = 1'b0;
      ifa.wready = 1'b1;
      tick();
      ifa.wready = 1'b0;
      chk("mid_wdata_beat1", 256'(ifa.wdata), 256'(32'hAAAA0001));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_awvalid", 256'(ifa.awvalid), 256'(0));
      chk("mid_rst_wvalid_wlast", 256'({ifa.wvalid, ifa.wlast}), 256'(0));
      chk("mid_rst_bready_rready", 256'({ifa.bready, ifa.rready}), 256'(0));
      chk("mid_rst_awaddr", 256'(ifa.awaddr), 256'(0));
      chk("mid_rst_rsp", 256'({rsp_valid_a, rsp_err_a}), 256'(0));
      chk("mid_rst_rdata", 256'(rsp_rdata_a), 256'(0));
      tick();
      tick();
      rst_n = 1'b1;
      chk("mid_req_ready", 256'(req_ready_a), 256'(1));
      read_a(32'h0000_401C, 32'h0000_4010, 32'h51, 4, 3, -1, 1'b0, 1'b1,
             128'h00000054_00000053_00000052_00000051);

      // Wide instance under random WREADY backpressure.
      idle_slaves();
      line_b = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
      req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 32'h0000_8034; req_wdata_b = line_b;
      tick();
      req_valid_b = 1'b0;
      ifb.awready = 1'b1;
      beat = 0; cyc = 0; have_prev = 0; aw_seen = 0; prev = '0;
      while ((beat < 4 || !aw_seen) && cyc < 200) begin
         if (have_prev) begin
            chk("b_wvalid_held", 256'(ifb.wvalid), 256'(1));
            chk("b_wdata_stable", 256'(ifb.wdata), 256'(prev));
         end
         have_prev = 0;
         ifb.wready = 1'($urandom_range(0, 1));
         if (ifb.wvalid && !ifb.wready) begin
            have_prev = 1;
            prev = ifb.wdata;
         end
         if (ifb.wvalid && ifb.wready) begin
            chk("b_wdata", 256'(ifb.wdata), 256'(line_b[beat*64 +: 64]));
            chk("b_wlast", 256'(ifb.wlast), 256'(beat == 3));
            beat++;
         end
         if (ifb.awvalid && ifb.awready) begin
            chk("b_awaddr", 256'(ifb.awaddr), 256'(32'h0000_8020));
            chk("b_awlen", 256'(ifb.awlen), 256'(3));
            chk("b_awsize", 256'(ifb.awsize), 256'(3));
            aw_seen = 1;
         end
         tick();
         cyc++;
      end
      chk("b_wr_in_time", 256'(cyc < 200), 256'(1));
      ifb.awready = 1'b0; ifb.wready = 1'b0;
      cyc = 0;
      while (!ifb.bready && cyc < 20) begin tick(); cyc++; end
      chk("b_bready", 256'(ifb.bready), 256'(1));
      ifb.bvalid = 1'b1; ifb.bresp = RESP_OKAY;
      tick();
      ifb.bvalid = 1'b0;
      chk("b_wr_rsp", 256'({rsp_valid_b, rsp_write_b, rsp_err_b}), 256'(3'b110));

      // Wide instance under random RVALID gaps.
      req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 32'h0000_9000;
      tick();
      req_valid_b = 1'b0;
      chk("b_arvalid", 256'(ifb.arvalid), 256'(1));
      chk("b_arlen", 256'(ifb.arlen), 256'(3));
      ifb.arready = 1'b1;
      tick();
      ifb.arready = 1'b0;
      beat = 0; cyc = 0;
      while (beat < 4 && cyc < 200) begin
         ifb.rvalid = 1'($urandom_range(0, 1));
         ifb.rdata  = {32'hCAFE0000 + beat, 32'h0000BEE0 + beat};
         ifb.rlast  = (beat == 3);
         tick();
         if (ifb.rvalid) beat++;
         cyc++;
      end
      ifb.rvalid = 1'b0; ifb.rlast = 1'b0;
      chk("b_rd_rsp", 256'({rsp_valid_b, rsp_write_b, rsp_err_b}), 256'(3'b100));
      chk("b_rd_rdata", rsp_rdata_b,
          256'hCAFE0003_0000BEE3_CAFE0002_0000BEE2_CAFE0001_0000BEE1_CAFE0000_0000BEE0);
      tick();
      chk("b_rd_rsp_pulse", 256'(rsp_valid_b), 256'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
